// File: rtl/score_pkg.sv
// Shared types for the ping-pong scoreboard.
// Two-digit BCD scores, game state and digit limits.
package score_pkg;

  typedef enum logic {
    PLAY,
    WON
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/score_display_ctrl_if.sv
// Point inputs and display outputs of the scoreboard.
// The controller sits on the slave side.
interface score_display_ctrl_if;
  import score_pkg::*;

  logic       pt_p1;
  logic       pt_p2;
  logic       new_game;
  bcd_t       p1_tens;
  bcd_t       p1_ones;
  bcd_t       p2_tens;
  bcd_t       p2_ones;
  logic [3:0] dis;
  logic       game_over;
  logic       winner;

  modport master (
    output pt_p1, pt_p2, new_game,
    input  p1_tens, p1_ones,
    input  p2_tens, p2_ones,
    input  dis, game_over, winner
  );

  modport slave (
    input  pt_p1, pt_p2, new_game,
    output p1_tens, p1_ones,
    output p2_tens, p2_ones,
    output dis, game_over, winner
  );

endinterface

// File: rtl/score_display_ctrl_bcd_cnt2.sv
// Two-digit saturating BCD counter, 00..99.
// Also exposes the next tens digit for registered blanking.
module bcd_cnt2
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output bcd_t       tens,
  output bcd_t       ones,
  output bcd_t       nxt_tens,
  output logic [6:0] bin
);

  bcd_t tens_q, tens_d;
  bcd_t ones_q, ones_d;
  logic at_max;

  assign at_max = (tens_q == BCD_MAX_DIGIT) &&
                  (ones_q == BCD_MAX_DIGIT);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (inc && !at_max) begin
      if (ones_q == BCD_MAX_DIGIT) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens     = tens_q;
  assign ones     = ones_q;
  assign nxt_tens = tens_d;
  assign bin      = ({3'd0, tens_q} * 7'd10) +
                    {3'd0, ones_q};

endmodule

// File: rtl/score_display_ctrl.sv
// Ping-pong scoreboard: scores, win rule, blink
// of the winner's digits and leading-zero blanking.
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int WIN_SCORE  = 11,
  parameter int WIN_MARGIN = 2,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  score_display_ctrl_if.slave  bus
);

  localparam int CW = $clog2(BLINK_DIV);

  state_t        state_q, state_d;
  logic          winner_q, winner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          off_q, off_d;
  logic [3:0]    dis_q, dis_d;

  bcd_t       p1_t, p1_o, p1_nt;
  bcd_t       p2_t, p2_o, p2_nt;
  logic [6:0] p1_bin, p2_bin;
  logic [7:0] p1_nxt, p2_nxt;
  logic       pt_ok, inc1, inc2;
  logic       win1, win2, blank;

  assign pt_ok = (state_q == PLAY) &&
                 !bus.new_game &&
                 (bus.pt_p1 ^ bus.pt_p2);

  // A saturated score ignores the point, so it cannot trigger a win.
  assign inc1 = pt_ok && bus.pt_p1 &&
                (p1_bin != 7'd99);
  assign inc2 = pt_ok && bus.pt_p2 &&
                (p2_bin != 7'd99);

  assign p1_nxt = {1'b0, p1_bin} + 8'd1;
  assign p2_nxt = {1'b0, p2_bin} + 8'd1;

  assign win1 = inc1 &&
    (p1_nxt >= 8'(WIN_SCORE)) &&
    (p1_nxt >= {1'b0, p2_bin} + 8'(WIN_MARGIN));
  assign win2 = inc2 &&
    (p2_nxt >= 8'(WIN_SCORE)) &&
    (p2_nxt >= {1'b0, p1_bin} + 8'(WIN_MARGIN));

  bcd_cnt2 u_p1 (
    .clk      (clk),
    .rst      (rst),
    .inc      (inc1),
    .clr      (bus.new_game),
    .tens     (p1_t),
    .ones     (p1_o),
    .nxt_tens (p1_nt),
    .bin      (p1_bin)
  );

  bcd_cnt2 u_p2 (
    .clk      (clk),
    .rst      (rst),
    .inc      (inc2),
    .clr      (bus.new_game),
    .tens     (p2_t),
    .ones     (p2_o),
    .nxt_tens (p2_nt),
    .bin      (p2_bin)
  );

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    unique case (state_q)
      PLAY: begin
        if (win1 || win2) begin
          state_d  = WON;
          winner_d = win2;
          cnt_d    = '0;
          off_d    = 1'b0;
        end
      end
      WON: begin
        if (cnt_q == CW'(BLINK_DIV - 1)) begin
          cnt_d = '0;
          off_d = ~off_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = PLAY;
    endcase
    if (bus.new_game) begin
      state_d  = PLAY;
      winner_d = 1'b0;
      cnt_d    = '0;
      off_d    = 1'b0;
    end
  end

  // Blanking is built from next-state values so it lands with the digits.
  assign blank = (state_d == WON) && off_d;

  always_comb begin
    dis_d    = 4'b0000;
    dis_d[3] = (p1_nt == 4'd0) ||
               (blank && !winner_d);
    dis_d[2] = blank && !winner_d;
    dis_d[1] = (p2_nt == 4'd0) ||
               (blank && winner_d);
    dis_d[0] = blank && winner_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PLAY;
      winner_q <= 1'b0;
      cnt_q    <= '0;
      off_q    <= 1'b0;
      dis_q    <= 4'b1010;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      off_q    <= off_d;
      dis_q    <= dis_d;
    end
  end

  assign bus.p1_tens   = p1_t;
  assign bus.p1_ones   = p1_o;
  assign bus.p2_tens   = p2_t;
  assign bus.p2_ones   = p2_o;
  assign bus.dis       = dis_q;
  assign bus.game_over = (state_q == WON);
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench: driver pushes model results,
// monitor pops and compares after each clock edge.
module tb_score_display_ctrl;

  localparam int WS = 11;
  localparam int WM = 2;
  localparam int BD = 4;

  typedef struct packed {
    logic [3:0] t1;
    logic [3:0] o1;
    logic [3:0] t2;
    logic [3:0] o2;
    logic [3:0] dis;
    logic       go;
    logic       w;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  score_display_ctrl_if bus ();

  score_display_ctrl #(
    .WIN_SCORE  (WS),
    .WIN_MARGIN (WM),
    .BLINK_DIV  (BD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int s1 = 0;
  int s2 = 0;
  bit over = 0;
  bit win = 0;
  int t_won = 0;

  task automatic model(input bit r, input bit a,
                       input bit b, input bit n);
    if (r || n) begin
      s1 = 0; s2 = 0; over = 0;
      win = 0; t_won = 0;
    end else if (over) begin
      t_won++;
    end else if (a != b) begin
      if (a && s1 < 99) begin
        s1++;
        if (s1 >= WS && s1 - s2 >= WM) begin
          over = 1; win = 0; t_won = 0;
        end
      end
      if (b && s2 < 99) begin
        s2++;
        if (s2 >= WS && s2 - s1 >= WM) begin
          over = 1; win = 1; t_won = 0;
        end
      end
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    bit off;
    off = over && (((t_won / BD) % 2) == 1);
    e.t1 = 4'(s1 / 10);
    e.o1 = 4'(s1 % 10);
    e.t2 = 4'(s2 / 10);
    e.o2 = 4'(s2 % 10);
    e.dis[3] = (s1 < 10) || (off && !win);
    e.dis[2] = off && !win;
    e.dis[1] = (s2 < 10) || (off && win);
    e.dis[0] = off && win;
    e.go = over;
    e.w  = over ? win : 1'b0;
    return e;
  endfunction

  task automatic step(input bit r, input bit a,
                      input bit b, input bit n);
    @(negedge clk);
    rst          = r;
    bus.pt_p1    = a;
    bus.pt_p2    = b;
    bus.new_game = n;
    model(r, a, b, n);
    q.push_back(expect_now());
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0);
  endtask

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h",
               nm, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("digits",
            {bus.p1_tens, bus.p1_ones,
             bus.p2_tens, bus.p2_ones},
            {e.t1, e.o1, e.t2, e.o2});
        chk("dis", 16'(bus.dis), 16'(e.dis));
        chk("game_over", 16'(bus.game_over),
            16'(e.go));
        chk("winner", 16'(bus.winner), 16'(e.w));
      end
    end
  end

  initial begin : driver
    int drain;
    bus.pt_p1    = 1'b0;
    bus.pt_p2    = 1'b0;
    bus.new_game = 1'b0;

    step(1, 0, 0, 0);
    idle(2);
    // carry into tens, then an 11-0 win
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0);
    idle(3);
    step(0, 0, 0, 1);
    // deuce
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
    end
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    idle(2);
    // simultaneous points at 3-4
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    idle(1);
    // P2 wins 1-11, blink, points ignored
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 1, 0);
    idle(10);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    idle(8);
    step(0, 0, 0, 1);
    idle(1);
    // reset mid-blink
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0);
    idle(6);
    step(1, 0, 0, 0);
    idle(1);
    step(0, 1, 0, 1);
    idle(1);
    // long deuce into saturation at 99
    for (int i = 0; i < 98; i++) begin
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
    end
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    idle(2);
    step(0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 79) == 0);
    end
    step(0, 0, 0, 0);

    drain = 0;
    while (q.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d left want 0",
               q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
